main_memory_ctrl: RTL and testbench

Backing-store controller directly downstream of the 2-way set-associative cache. It services the cache's miss traffic: an optional write-back of an evicted dirty block, followed by an optional fill read, each with a fixed modelled memory latency. The cache raises one request per miss and waits for a single-cycle response pulse.

---
 rtl/main_memory_ctrl_pkg.sv | 22 ++
 rtl/main_memory_ctrl_timer.sv | 37 +++
 rtl/main_memory_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_main_memory_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/main_memory_ctrl_pkg.sv
// Shared definitions for the main-memory controller behind the 2-way cache.
// Optional statistics counters are enabled with the MAIN_MEM_STATS_EN macro.
package main_memory_ctrl_pkg;

  // Block address / data widths shared with the cache
  localparam int MEM_ADDR_W  = 5;
  localparam int MEM_DATA_W  = 4;

  // Phase counter width (LATENCY legal range 1..15)
  localparam int PHASE_CNT_W = 4;

  // Width of the optional saturating statistics counters
  localparam int STAT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_RD,
    ST_RESP
  } mem_state_e;

endpackage

// File: rtl/main_memory_ctrl_timer.sv
// mem_phase_timer: loadable down-counter timing one memory phase (WB or RD).
// done is high while the count reads zero.
module mem_phase_timer
  import main_memory_ctrl_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [PHASE_CNT_W-1:0] load_val,
  output logic                   done
);

  logic [PHASE_CNT_W-1:0] count_q;
  logic [PHASE_CNT_W-1:0] count_d;

  // Next count: reload, else decrement until zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - PHASE_CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: services cache misses with an optional write-back followed
// by an optional fill read, each phase lasting LATENCY cycles.
// Define MAIN_MEM_STATS_EN to add saturating fill/write-back counters.
module main_memory_ctrl
  import main_memory_ctrl_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int LATENCY = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [DATA_W-1:0] req_wb_data,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] req_fill_addr,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
`ifdef MAIN_MEM_STATS_EN
  output logic [STAT_W-1:0] stat_rd_cnt,
  output logic [STAT_W-1:0] stat_wr_cnt,
`endif
  output logic              busy
);

  localparam int                     DEPTH  = 2 ** ADDR_W;
  localparam logic [PHASE_CNT_W-1:0] LAT_M1 = PHASE_CNT_W'(LATENCY - 1);

  mem_state_e        state_q, state_d;
  logic              fill_q, fill_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic accept;
  logic timer_load;
  logic timer_done;
  logic mem_we;
  logic rd_fire;

  mem_phase_timer u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (LAT_M1),
    .done     (timer_done)
  );

  assign accept = req_valid && req_ready_q && (req_wb || req_fill);

  // Next-state, request capture, phase control and registered-output decode
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    fill_addr_d = fill_addr_q;
    rdata_d     = rdata_q;
    timer_load  = 1'b0;
    mem_we      = 1'b0;
    rd_fire     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          fill_d      = req_fill;
          wb_addr_d   = req_wb_addr;
          wb_data_d   = req_wb_data;
          fill_addr_d = req_fill_addr;
          timer_load  = 1'b1;
          state_d     = req_wb ? ST_WB : ST_RD;
        end
      end
      ST_WB: begin
        if (timer_done) begin
          mem_we = 1'b1;
          if (fill_q) begin
            timer_load = 1'b1;
            state_d    = ST_RD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RD: begin
        if (timer_done) begin
          rd_fire = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The write-back commits at an earlier edge, so mem_q already holds it here
    if (rd_fire) begin
      rdata_d = mem_q[fill_addr_q];
    end

    req_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  // Controller state, captured request and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fill_q       <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      fill_addr_q  <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      fill_addr_q  <= fill_addr_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  // Backing store: reset image mem[i] = i, written at write-back commit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else if (mem_we) begin
      mem_q[wb_addr_q] <= wb_data_q;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;

`ifdef MAIN_MEM_STATS_EN
  logic [STAT_W-1:0] stat_rd_q, stat_rd_d;
  logic [STAT_W-1:0] stat_wr_q, stat_wr_d;

  // Saturating event counters
  always_comb begin
    stat_rd_d = stat_rd_q;
    stat_wr_d = stat_wr_q;
    if (rd_fire && (stat_rd_q != '1)) begin
      stat_rd_d = stat_rd_q + STAT_W'(1);
    end
    if (mem_we && (stat_wr_q != '1)) begin
      stat_wr_d = stat_wr_q + STAT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_d;
      stat_wr_q <= stat_wr_d;
    end
  end

  assign stat_rd_cnt = stat_rd_q;
  assign stat_wr_cnt = stat_wr_q;
`endif

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: directed vector table, randomized
// requests against a behavioural memory model, and reset/ignore corner cases.
module tb_main_memory_ctrl;

  localparam int LAT = 3;
  localparam int AW  = 5;
  localparam int DW  = 4;

  logic          clock;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wb;
  logic [AW-1:0] req_wb_addr;
  logic [DW-1:0] req_wb_data;
  logic          req_fill;
  logic [AW-1:0] req_fill_addr;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          busy;
`ifdef MAIN_MEM_STATS_EN
  logic [7:0]    stat_rd_cnt;
  logic [7:0]    stat_wr_cnt;
`endif

  main_memory_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .LATENCY (LAT)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wb        (req_wb),
    .req_wb_addr   (req_wb_addr),
    .req_wb_data   (req_wb_data),
    .req_fill      (req_fill),
    .req_fill_addr (req_fill_addr),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
`ifdef MAIN_MEM_STATS_EN
    .stat_rd_cnt   (stat_rd_cnt),
    .stat_wr_cnt   (stat_wr_cnt),
`endif
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain memory image plus last returned fill data
  int model_mem [32];
  int model_rdata;

  typedef struct {
    bit            wb;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit            fill;
    logic [AW-1:0] fa;
    int            exp_lat;
    int            exp_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = i % 16;
    model_rdata = 0;
  endtask

  // Predicts latency and resp_rdata from the request rules
  task automatic model_req(input bit wb, input int wa, input int wd, input bit fill,
                           input int fa, output int lat, output int rd);
    lat = 1;
    if (wb) begin
      model_mem[wa] = wd;
      lat += LAT;
    end
    if (fill) begin
      model_rdata = model_mem[fa];
      lat += LAT;
    end
    rd = model_rdata;
  endtask

  task automatic apply_reset();
    req_valid = 1'b0;
    req_wb    = 1'b0;
    req_fill  = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    model_reset();
  endtask

  // Issues one request starting at a negedge in IDLE; returns at a negedge in IDLE
  task automatic do_req(input bit wb, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit fill, input logic [AW-1:0] fa,
                        output int lat, output int rd, output int low_cnt);
    req_valid     = 1'b1;
    req_wb        = wb;
    req_wb_addr   = wa;
    req_wb_data   = wd;
    req_fill      = fill;
    req_fill_addr = fa;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_wb    = 1'b0;
    req_fill  = 1'b0;
    lat       = -1;
    low_cnt   = 0;
    rd        = int'(resp_rdata);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clock);
      if (!req_ready) low_cnt++;
      if (resp_valid) begin
        lat = k;
        rd  = int'(resp_rdata);
        break;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    int lat, rd, low, exp_lat, exp_rd, pulses;
    bit wb, fill;
    logic [AW-1:0] wa, fa;
    logic [DW-1:0] wd;

    req_wb_addr   = '0;
    req_wb_data   = '0;
    req_fill_addr = '0;
    apply_reset();

    chk("rst_req_ready",  int'(req_ready),  1);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_rdata", int'(resp_rdata), 0);
    chk("rst_busy",       int'(busy),       0);

    // Directed table, expectations worked out by hand from the reset image
    vecs[0] = '{wb:0, wa:5'd0,  wd:4'h0, fill:1, fa:5'd2,  exp_lat:4, exp_rd:2};
    vecs[1] = '{wb:1, wa:5'd7,  wd:4'h9, fill:0, fa:5'd0,  exp_lat:4, exp_rd:2};
    vecs[2] = '{wb:0, wa:5'd0,  wd:4'h0, fill:1, fa:5'd7,  exp_lat:4, exp_rd:9};
    vecs[3] = '{wb:1, wa:5'd5,  wd:4'hA, fill:1, fa:5'd5,  exp_lat:7, exp_rd:10};
    vecs[4] = '{wb:1, wa:5'd0,  wd:4'h3, fill:1, fa:5'd0,  exp_lat:7, exp_rd:3};
    vecs[5] = '{wb:0, wa:5'd0,  wd:4'h0, fill:1, fa:5'd31, exp_lat:4, exp_rd:15};

    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec%0d_ready", i), int'(req_ready), 1);
      do_req(vecs[i].wb, vecs[i].wa, vecs[i].wd, vecs[i].fill, vecs[i].fa, lat, rd, low);
      model_req(vecs[i].wb, int'(vecs[i].wa), int'(vecs[i].wd), vecs[i].fill,
                int'(vecs[i].fa), exp_lat, exp_rd);
      chk($sformatf("vec%0d_lat", i),       lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_rdata", i),     rd,  vecs[i].exp_rd);
      chk($sformatf("vec%0d_ready_low", i), low, vecs[i].exp_lat);
      chk($sformatf("vec%0d_resp_1cyc", i), int'(resp_valid), 0);
    end

    // Flagless request is ignored, then a fill on the next cycle is served normally
    req_valid = 1'b1;
    req_wb    = 1'b0;
    req_fill  = 1'b0;
    @(negedge clock);
    chk("ignore_ready", int'(req_ready), 1);
    chk("ignore_busy",  int'(busy),      0);
    do_req(1'b0, '0, '0, 1'b1, 5'd3, lat, rd, low);
    model_req(1'b0, 0, 0, 1'b1, 3, exp_lat, exp_rd);
    chk("after_ignore_lat",   lat, exp_lat);
    chk("after_ignore_rdata", rd,  exp_rd);

    // Randomized requests against the model
    for (int i = 0; i < 60; i++) begin
      wb   = 1'($urandom_range(0, 1));
      fill = 1'($urandom_range(0, 1));
      if (!wb && !fill) fill = 1'b1;
      wa = AW'($urandom_range(0, 31));
      wd = DW'($urandom_range(0, 15));
      fa = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      do_req(wb, wa, wd, fill, fa, lat, rd, low);
      model_req(wb, int'(wa), int'(wd), fill, int'(fa), exp_lat, exp_rd);
      chk($sformatf("rnd%0d_lat", i),   lat, exp_lat);
      chk($sformatf("rnd%0d_rdata", i), rd,  exp_rd);
    end

    // Reset during the write-back phase before its commit edge
    req_valid   = 1'b1;
    req_wb      = 1'b1;
    req_wb_addr = 5'd1;
    req_wb_data = 4'hF;
    req_fill    = 1'b0;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_wb    = 1'b0;
    @(negedge clock);
    chk("abort_busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("abort_ready", int'(req_ready),  1);
    chk("abort_busy",  int'(busy),       0);
    chk("abort_rdata", int'(resp_rdata), 0);
    pulses = 0;
    repeat (2) begin
      @(negedge clock);
      if (resp_valid) pulses++;
    end
    reset_n = 1'b1;
    model_reset();
    repeat (6) begin
      @(negedge clock);
      if (resp_valid) pulses++;
    end
    chk("abort_no_resp", pulses, 0);
    do_req(1'b0, '0, '0, 1'b1, 5'd1, lat, rd, low);
    model_req(1'b0, 0, 0, 1'b1, 1, exp_lat, exp_rd);
    chk("abort_fill_lat",   lat, exp_lat);
    chk("abort_fill_rdata", rd,  exp_rd);

`ifdef MAIN_MEM_STATS_EN
    apply_reset();
    chk("stat_rd_rst", int'(stat_rd_cnt), 0);
    for (int i = 0; i < 300; i++) begin
      do_req(1'b0, '0, '0, 1'b1, AW'(i % 32), lat, rd, low);
    end
    chk("stat_rd_sat", int'(stat_rd_cnt), 255);
    chk("stat_wr_zero", int'(stat_wr_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
